// File: rtl/mesh_term_ingress.sv
// ============================================================================
// Module   : mesh_term_ingress
// Brief    : Terminal-side FWFT ingress FIFO feeding one external port of
//            mesh_gnrtr; clears Nxtjp on write. Optional destination filter
//            enabled by defining INGRESS_DST_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_term_ingress #(
    parameter int         ROWS       = 4,
    parameter int         COLUMS     = 4,
    parameter int         pckg_sz    = 40,
    parameter int         fifo_depth = 4,
    parameter logic [7:0] bdcst      = 8'hFF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic [pckg_sz-1:0]                 data_in,
    output logic                               full,
    output logic                               pndng,
    output logic [pckg_sz-1:0]                 data_out,
    input  logic                               popin,
    output logic [$clog2(fifo_depth+1)-1:0]    count,
    output logic                               ovf,
    output logic [7:0]                         drop_cnt
);

    localparam int                CW       = $clog2(fifo_depth + 1);
    localparam int                PW       = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [PW-1:0]     PTR_LAST = PW'(fifo_depth - 1);
    localparam logic [CW-1:0]     DEPTH    = CW'(fifo_depth);
    // Masking rather than slicing keeps every input bit in use; Nxtjp is forced to zero.
    localparam logic [pckg_sz-1:0] NXT_CLR_MASK = {8'h00, {(pckg_sz-8){1'b1}}};

    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q,  count_d;
    logic               ovf_q,    ovf_d;

    logic               w_pndng;
    logic               w_full;
    logic               w_pop_acc;
    logic               w_push_acc;
    logic               w_push_lost;
    logic               w_dest_ok;
    logic [pckg_sz-1:0] w_wr_word;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef INGRESS_DST_CHECK_EN
    localparam logic [3:0] ROW_MAX  = 4'(ROWS);
    localparam logic [3:0] COL_MAX  = 4'(COLUMS);
    localparam logic [3:0] ROW_LAST = 4'(ROWS + 1);
    localparam logic [3:0] COL_LAST = 4'(COLUMS + 1);

    logic [3:0] w_row;
    logic [3:0] w_colum;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign w_row   = data_in[pckg_sz-9 -: 4];
    assign w_colum = data_in[pckg_sz-13 -: 4];

    // Legal terminals sit on the mesh border, excluding the four corners.
    assign w_dest_ok = ({w_row, w_colum} == bdcst)
                    || (((w_row == 4'd0) || (w_row == ROW_LAST))
                        && (w_colum >= 4'd1) && (w_colum <= COL_MAX))
                    || (((w_colum == 4'd0) || (w_colum == COL_LAST))
                        && (w_row >= 4'd1) && (w_row <= ROW_MAX));

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (push && !w_dest_ok && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign w_dest_ok = 1'b1;
    assign drop_cnt  = 8'h00;
`endif

    assign w_pndng     = (count_q != '0);
    assign w_full      = (count_q == DEPTH);
    assign w_pop_acc   = popin && w_pndng;
    assign w_push_acc  = push && w_dest_ok && (!w_full || w_pop_acc);
    assign w_push_lost = push && w_dest_ok && w_full && !w_pop_acc;
    assign w_wr_word   = data_in & NXT_CLR_MASK;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_pop_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (w_push_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        case ({w_push_acc, w_pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (w_push_lost) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is gated to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            mem_q[wr_ptr_q] <= w_wr_word;
        end
    end

    assign pndng    = w_pndng;
    assign full     = w_full;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign data_out = w_pndng ? mem_q[rd_ptr_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_mesh_term_ingress.sv
// ============================================================================
// Module   : tb_mesh_term_ingress
// Brief    : Directed self-checking bench for mesh_term_ingress.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesh_term_ingress;

    localparam int PSZ = 40;

    logic           clk;
    logic           reset;
    logic           push;
    logic [PSZ-1:0] data_in;
    logic           full;
    logic           pndng;
    logic [PSZ-1:0] data_out;
    logic           popin;
    logic [2:0]     count;
    logic           ovf;
    logic [7:0]     drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [PSZ-1:0] q [8];
    logic [PSZ-1:0] pkt;

    mesh_term_ingress #(
        .ROWS       (4),
        .COLUMS     (4),
        .pckg_sz    (PSZ),
        .fifo_depth (4),
        .bdcst      (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .data_in  (data_in),
        .full     (full),
        .pndng    (pndng),
        .data_out (data_out),
        .popin    (popin),
        .count    (count),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PSZ-1:0] mk(input logic [7:0] nxt, input logic [3:0] row,
                                          input logic [3:0] col, input logic mode,
                                          input logic [22:0] pay);
        return {nxt, row, col, mode, pay};
    endfunction

    function automatic logic [PSZ-1:0] clr(input logic [PSZ-1:0] p);
        logic [PSZ-1:0] r;
        r = p;
        r[PSZ-1 -: 8] = 8'h00;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs held across the rising edge, outputs settle 1 time unit later.
    task automatic tick(input logic p, input logic [PSZ-1:0] d, input logic pop);
        push    = p;
        data_in = d;
        popin   = pop;
        @(posedge clk);
        #1;
        push  = 1'b0;
        popin = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        push    = 1'b0;
        popin   = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_pndng", 64'(pndng), 64'd0);
        chk("rst_full",  64'(full),  64'd0);
        chk("rst_ovf",   64'(ovf),   64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        chk("rst_dout",  64'(data_out), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rel_dout", 64'(data_out), 64'd0);

        // First packet: row 0, colum 2, mode 1, payload 1
        pkt = mk(8'h00, 4'd0, 4'd2, 1'b1, 23'd1);
        tick(1'b1, pkt, 1'b0);
        chk("p1_pndng", 64'(pndng), 64'd1);
        chk("p1_dout",  64'(data_out), 64'h00_0_2_800001);
        chk("p1_count", 64'(count), 64'd1);
        tick(1'b0, '0, 1'b1);
        chk("p1_pop_pndng", 64'(pndng), 64'd0);

        // Nxtjp cleared on write
        pkt = mk(8'hAB, 4'd5, 4'd1, 1'b0, 23'hFF);
        tick(1'b1, pkt, 1'b0);
        chk("nxt_clr_dout", 64'(data_out), 64'h00_5_1_0000FF);
        tick(1'b0, '0, 1'b1);

        // Overflow: 5 pushes into depth 4
        for (int i = 0; i < 5; i++) begin
            q[i] = mk(8'h30 + 8'(i), 4'd0, 4'(i % 4 + 1), 1'b0, 23'h100 + 23'(i));
            tick(1'b1, q[i], 1'b0);
            if (i == 3) begin
                chk("ovf_full4",  64'(full),  64'd1);
                chk("ovf_ovf4",   64'(ovf),   64'd0);
            end
        end
        chk("ovf_count", 64'(count), 64'd4);
        chk("ovf_flag",  64'(ovf),   64'd1);
        chk("ovf_full5", 64'(full),  64'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_order%0d", i), 64'(data_out), 64'(clr(q[i])));
            tick(1'b0, '0, 1'b1);
        end
        chk("ovf_drained_pndng", 64'(pndng), 64'd0);
        chk("ovf_drained_full",  64'(full),  64'd0);
        chk("ovf_sticky",        64'(ovf),   64'd1);

        // Async reset clears ovf without a clock edge
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_ovf_clr", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Fill, then 3 cycles of simultaneous push+pop at full across pointer wrap
        for (int i = 0; i < 7; i++) begin
            q[i] = mk(8'h50 + 8'(i), 4'd5, 4'(i % 4 + 1), 1'(i % 2), 23'h200 + 23'(i));
        end
        for (int i = 0; i < 4; i++) tick(1'b1, q[i], 1'b0);
        chk("pp_full", 64'(full), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pp_head%0d", i), 64'(data_out), 64'(clr(q[i])));
            tick(1'b1, q[4+i], 1'b1);
            chk($sformatf("pp_count%0d", i), 64'(count), 64'd4);
        end
        chk("pp_ovf", 64'(ovf), 64'd0);
        for (int i = 3; i < 7; i++) begin
            chk($sformatf("pp_drain%0d", i), 64'(data_out), 64'(clr(q[i])));
            tick(1'b0, '0, 1'b1);
        end
        chk("pp_empty", 64'(pndng), 64'd0);

        // Push with popin while empty
        pkt = mk(8'h11, 4'd3, 4'd5, 1'b1, 23'h777);
        tick(1'b1, pkt, 1'b1);
        chk("pe_count", 64'(count), 64'd1);
        chk("pe_dout",  64'(data_out), 64'(clr(pkt)));
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        chk("pop_empty_count", 64'(count), 64'd0);
        chk("pop_empty_ovf",   64'(ovf),   64'd0);

        // Destination filter
        tick(1'b1, mk(8'h00, 4'd0, 4'd0, 1'b0, 23'h1), 1'b0);
        tick(1'b1, mk(8'h00, 4'd3, 4'd3, 1'b0, 23'h2), 1'b0);
        pkt = mk(8'h00, 4'hF, 4'hF, 1'b0, 23'h3);
        tick(1'b1, pkt, 1'b0);
`ifdef INGRESS_DST_CHECK_EN
        chk("dst_drop",  64'(drop_cnt), 64'd2);
        chk("dst_count", 64'(count),    64'd1);
        chk("dst_dout",  64'(data_out), 64'(clr(pkt)));
        chk("dst_ovf",   64'(ovf),      64'd0);
`else
        chk("dst_drop",  64'(drop_cnt), 64'd0);
        chk("dst_count", 64'(count),    64'd3);
        chk("dst_dout",  64'(data_out), 64'(mk(8'h00, 4'd0, 4'd0, 1'b0, 23'h1)));
`endif
        for (int i = 0; i < 8 && pndng; i++) tick(1'b0, '0, 1'b1);
        chk("dst_drained", 64'(pndng), 64'd0);

        // Reach count=3 with ovf set, then async reset mid-cycle
        for (int i = 0; i < 5; i++) tick(1'b1, mk(8'h77, 4'd0, 4'd1, 1'b0, 23'(i)), 1'b0);
        tick(1'b0, '0, 1'b1);
        chk("ar_pre_count", 64'(count), 64'd3);
        chk("ar_pre_ovf",   64'(ovf),   64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_pndng", 64'(pndng), 64'd0);
        chk("ar_ovf",   64'(ovf),   64'd0);
        chk("ar_dout",  64'(data_out), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1'b0, '0, 1'b1);
        chk("ar_pop_empty_count", 64'(count), 64'd0);
        chk("ar_pop_empty_full",  64'(full),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
